// File: rtl/xup_tri_bus_reader_if.sv
// Signal bundle between the tri-state bus reader, the remote driver bank and the sample consumer.
// The slave modport is the reader's view; master is the surrounding system's view.
interface xup_tri_bus_reader_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic [SIZE-1:0] bus_in;
  logic            data_ready;
  logic            drive_enable;
  logic [SIZE-1:0] data_out;
  logic            data_valid;
  logic            busy;
  logic            start_dropped;
  logic [15:0]     read_count;

  modport slave (
    input  start, bus_in, data_ready,
    output drive_enable, data_out, data_valid, busy, start_dropped, read_count
  );

  modport master (
    output start, bus_in, data_ready,
    input  drive_enable, data_out, data_valid, busy, start_dropped, read_count
  );
endinterface

// File: rtl/xup_tri_bus_reader.sv
// Read-side controller for a shared tri-state bus: enables the remote driver, waits the
// turnaround, samples, lets the bus float, and holds the sample on a valid/ready output.
module xup_tri_bus_reader #(
  parameter int SIZE       = 8,
  parameter int TURNAROUND = 2,
  parameter int RELEASE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  xup_tri_bus_reader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENABLE,
    S_RELEASE
  } state_t;

  localparam int           REL_M1      = (RELEASE > 0) ? RELEASE - 1 : 0;
  localparam logic [3:0]   LP_TA_LOAD  = 4'(TURNAROUND - 1);
  localparam logic [3:0]   LP_REL_LOAD = 4'(REL_M1);

  state_t          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_drive_en, w_drive_en_next;
  logic [SIZE-1:0] r_data, w_data_next;
  logic            r_valid, w_valid_next;
  logic [15:0]     r_count, w_count_next;
  logic            r_dropped, w_dropped_next;
  logic            w_slot_free;
  logic            w_can_accept;
  logic            w_sample;

  // The output slot is usable on this edge if it is empty or being consumed right now.
  assign w_slot_free = !r_valid || bus.data_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_drive_en <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_count    <= 16'd0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_drive_en <= w_drive_en_next;
      r_data     <= w_data_next;
      r_valid    <= w_valid_next;
      r_count    <= w_count_next;
      r_dropped  <= w_dropped_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_drive_en_next = r_drive_en;
    w_data_next     = r_data;
    w_valid_next    = r_valid && !bus.data_ready;
    w_count_next    = r_count;
    w_dropped_next  = 1'b0;
    w_can_accept    = 1'b0;
    w_sample        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_can_accept = 1'b1;
      end
      S_ENABLE: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else if (w_slot_free) begin
          // Holding off the sample here (driver stays enabled) only happens for a read
          // chained straight out of the previous sample edge while the consumer stalls.
          w_sample = 1'b1;
          if (RELEASE > 0) begin
            w_state_next = S_RELEASE;
            w_cnt_next   = LP_REL_LOAD;
          end else begin
            w_state_next = S_IDLE;
            w_can_accept = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = S_IDLE;
          w_can_accept = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_sample) begin
      w_data_next     = bus.bus_in;
      w_valid_next    = 1'b1;
      w_count_next    = r_count + 16'd1;
      w_drive_en_next = 1'b0;
    end

    // Terminal edges of ENABLE/RELEASE accept exactly like IDLE so reads can run back to back.
    if (bus.start) begin
      if (w_can_accept && w_slot_free) begin
        w_state_next    = S_ENABLE;
        w_cnt_next      = LP_TA_LOAD;
        w_drive_en_next = 1'b1;
      end else begin
        w_dropped_next = 1'b1;
      end
    end
  end

  assign bus.drive_enable  = r_drive_en;
  assign bus.data_out      = r_data;
  assign bus.data_valid    = r_valid;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.start_dropped = r_dropped;
  assign bus.read_count    = r_count;

endmodule
